// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on both sides.
// Accepts one operation at a time (IDLE -> EXEC -> DONE -> IDLE).
//
// Ports:
//   ck        clock, rising edge
//   rst_n     asynchronous active-low reset
//   A, B      operands; B[SHW-1:0] is the shift amount for shift ops
//   CTR       4-bit opcode
//   in_valid  operation offered      in_ready   accepting (IDLE only)
//   O, FLAGS  registered result and {C,V,N,Z}
//   out_valid result held            out_ready  consumer takes result
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       CTR,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] O,
    output logic [3:0]       FLAGS,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [3:0] OpMul = 4'b0100;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]         ctr_q, ctr_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;  // product register for MUL, shifter for shifts
    logic               cf_q, cf_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic [3:0]         flags_q, flags_d;

    logic               cin;
    logic [WIDTH:0]     sum_ext, dif_ext, mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH-1:0]   sh_next, res;
    logic               sh_out, c_res, v_res, finish;
    logic [SHW-1:0]     amt;

    // ADC/SBB share the adder/subtractor with ADD/SUB; CTR[1] selects carry-in.
    assign cin     = ctr_q[1] & cf_q;
    assign sum_ext = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
    assign dif_ext = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
    assign amt     = b_q[SHW-1:0];

    // Shift-add step: add A into the high half when the multiplier LSB is set,
    // then shift the whole register right by one.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    always_comb begin
        sh_next = work_q[WIDTH-1:0];
        sh_out  = 1'b0;
        case (ctr_q[1:0])
            2'b00: begin  // SRL
                sh_out  = work_q[0];
                sh_next = {1'b0, work_q[WIDTH-1:1]};
            end
            2'b01: begin  // SLL
                sh_out  = work_q[WIDTH-1];
                sh_next = {work_q[WIDTH-2:0], 1'b0};
            end
            2'b10: begin  // ROR
                sh_out  = work_q[0];
                sh_next = {work_q[0], work_q[WIDTH-1:1]};
            end
            default: begin  // ROL
                sh_out  = work_q[WIDTH-1];
                sh_next = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctr_d   = ctr_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        cf_d    = cf_q;
        o_d     = o_q;
        flags_d = flags_q;
        res     = '0;
        c_res   = cf_q;
        v_res   = 1'b0;
        finish  = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d   = A;
                    b_d   = B;
                    ctr_d = CTR;
                    if (CTR == OpMul) begin
                        cnt_d  = SHW'(WIDTH - 1);
                        work_d = {{WIDTH{1'b0}}, B};
                    end else begin
                        work_d = {{WIDTH{1'b0}}, A};
                        if (CTR[3:2] == 2'b11 && B[SHW-1:0] != '0) begin
                            cnt_d = B[SHW-1:0] - 1'b1;
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    state_d = StExec;
                end
            end
            StExec: begin
                finish = (cnt_q == '0);
                if (!finish) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (ctr_q == OpMul) begin
                    work_d = mul_next;
                    res    = mul_next[WIDTH-1:0];
                    c_res  = |mul_next[2*WIDTH-1:WIDTH];
                end else if (ctr_q[3:2] == 2'b11) begin
                    if (amt == '0) begin
                        res = a_q;
                    end else begin
                        work_d[WIDTH-1:0] = sh_next;
                        res   = sh_next;
                        c_res = sh_out;
                    end
                end else begin
                    case (ctr_q)
                        4'b0000, 4'b0010: begin
                            res   = sum_ext[WIDTH-1:0];
                            c_res = sum_ext[WIDTH];
                            v_res = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) &
                                    (sum_ext[WIDTH-1] ^ a_q[WIDTH-1]);
                        end
                        4'b0001, 4'b0011: begin
                            res   = dif_ext[WIDTH-1:0];
                            c_res = dif_ext[WIDTH];
                            v_res = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                                    (dif_ext[WIDTH-1] ^ a_q[WIDTH-1]);
                        end
                        4'b1000: res = a_q & b_q;
                        4'b1001: res = a_q | b_q;
                        4'b1010: res = a_q ^ b_q;
                        4'b1011: res = ~a_q;
                        default: res = '0;  // unused opcodes
                    endcase
                end
                if (finish) begin
                    o_d     = res;
                    cf_d    = c_res;
                    flags_d = {c_res, v_res, res[WIDTH-1], (res == '0)};
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            ctr_q   <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            cf_q    <= 1'b0;
            o_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            cf_q    <= cf_d;
            o_q     <= o_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign O         = o_q;
    assign FLAGS     = flags_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's 8-bit registered ALU. It keeps the existing 4-bit opcode map and adds carry-chained add/subtract, an iterative shift-add multiplier, variable-amount shifts/rotates, status flags and valid/ready handshakes on both sides. It sits between the datapath register file and the writeback stage, and accepts one operation at a time.

## Interface
Parameters:
- WIDTH, 8, operand/result width; power of two, ≥4.
- SHW, clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- ck  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; low SHW bits give the shift amount for shift ops.
- CTR  in  4  opcode.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- O  out  WIDTH  registered result.
- FLAGS  out  4  registered {C,V,N,Z}.
- out_valid  out  1  O/FLAGS hold a result.
- out_ready  in  1  consumer takes result.

## Operation
- Opcodes:
  - 0000 ADD A+B
  - 0001 SUB A−B
  - 0010 ADC A+B+cf
  - 0011 SBB A−B−cf
  - 0100 MUL: low WIDTH bits of unsigned A×B
  - 1000 AND, 1001 OR, 1010 XOR, 1011 NOT A
  - 1100 SRL, 1101 SLL, 1110 ROR, 1111 ROL: each by amt = B[SHW-1:0]
  - 0101–0111: O=0, FLAGS={cf,0,0,1}
- States: IDLE → EXEC → DONE → IDLE.
  - IDLE: in_ready=1. On in_valid, latch A, B and CTR; load cycle counter; go to EXEC.
  - EXEC: one step per cycle.
    - MUL: one shift-add step per cycle, WIDTH cycles.
    - Shifts: one bit per cycle, max(amt,1) cycles; amt=0 passes A through.
    - All other ops: 1 cycle.
    - On the last step, write O and FLAGS, then go to DONE.
  - DONE: out_valid=1; O and FLAGS stable. On out_ready, go to IDLE.
- cf: internal carry register; its value is mirrored in FLAGS.C.
  - ADD/ADC: cf = carry-out.
  - SUB/SBB: cf = borrow (1 when the unsigned result wrapped).
  - MUL: cf = 1 if the high half of the product is nonzero.
  - SRL/SLL/ROR/ROL with amt≥1: cf = last bit shifted or rotated out.
  - Shifts with amt=0, logic ops and illegal opcodes: cf unchanged.
- V = signed overflow for ADD/SUB/ADC/SBB; 0 for all other ops.
- N = O[WIDTH-1]; Z = (O==0).
- All arithmetic is modulo 2^WIDTH; there is no saturation.
- in_valid is ignored outside IDLE. Operands are sampled only at the accept edge.

## Timing
- Reset (async, any state): state=IDLE, O=0, FLAGS=0, cf=0, out_valid=0, in_ready=1. The reset values are visible immediately, not at the next edge.
- Reset mid-EXEC or mid-DONE: the operation is discarded; no result is emitted.
- Accept at edge t0 (in_valid & in_ready). in_ready falls after t0.
- out_valid rises after edge t0+L, where:
  - L = 1 for add/sub/logic/illegal ops
  - L = WIDTH for MUL
  - L = max(amt,1) for shifts
- Output handshake at the first edge with out_valid & out_ready. out_valid falls and in_ready rises after that edge.
- Minimum issue period is L+2 cycles, reached when out_ready is held high.
- An ADC/SBB immediately after a producing op uses the cf written by that op.

## Test plan (WIDTH=8)
- ADD A=0x7F, B=0x01 → O=0x80, FLAGS C=0 V=1 N=1 Z=0; out_valid high after edge t0+1.
- ADD 0xFF+0x01, then ADC 0x00+0x00 → first result O=0x00 with C=1, Z=1; second result O=0x01 with C=0.
- MUL 0x12×0x10 → O=0x20, C=1; out_valid after edge t0+8; in_ready low throughout EXEC.
- ROL A=0x81, B=3 → O=0x0C, C=0, out_valid after edge t0+3. Then SRL A=0x81, B=0 → O=0x81, cf unchanged, out_valid after edge t0+1.
- Backpressure: hold out_ready=0 for 5 cycles while toggling in_valid, A and B → O, FLAGS and out_valid stable, in_ready=0. Release → in_ready=1 one edge later.
- Assert rst_n=0 during cycle 4 of a MUL → out_valid=0, O=0, FLAGS=0, in_ready=1 immediately. After release, a new ADD 0x02+0x03 gives O=0x05, C=0.
